// File: rtl/spi_sub.sv
// SPI subordinate for 128-bit AES block transfers: oversamples sclk/cs_n/mosi in
// the clk domain, assembles one word per frame MSB-first and shifts a response on miso.
module spi_sub #(
  parameter int WIDTH       = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int                CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(WIDTH);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_hist;
  logic                   cs_hist;

  // NOTE: non-blocking assignments in every clocked block, so each flop samples
  // the value its neighbour held before the edge and the shift order is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      // NOTE: cs_n is deliberately reset to "low" so that a frame already in
      // progress at reset release produces no falling edge and is not joined.
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      cs_hist   <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign sclk_fall = ~sclk_s & sclk_hist;
  assign cs_rise   = cs_s & ~cs_hist;
  assign cs_fall   = ~cs_s & cs_hist;

  // ---------------------------------------------------------------------------
  // Frame FSM and datapath
  // ---------------------------------------------------------------------------
  state_t           state, state_n;
  logic [WIDTH-1:0] tx_shift, tx_shift_n;
  logic [WIDTH-1:0] rx_shift, rx_shift_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] rx_data_n;
  logic             miso_n, rx_valid_n, frame_err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      tx_shift  <= tx_shift_n;
      rx_shift  <= rx_shift_n;
      bit_cnt   <= bit_cnt_n;
      miso      <= miso_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n     = state;
    tx_shift_n  = tx_shift;
    rx_shift_n  = rx_shift;
    bit_cnt_n   = bit_cnt;
    miso_n      = miso;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;

    unique case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (cs_fall) begin
          tx_shift_n = tx_data;
          rx_shift_n = '0;
          bit_cnt_n  = '0;
          miso_n     = tx_data[WIDTH-1];
          state_n    = ACTIVE;
        end
      end

      ACTIVE: begin
        // tx_shift advances once per sampled bit, so its MSB is always the bit
        // selected by bit_cnt in the original word.
        if (sclk_rise) begin
          miso_n = (bit_cnt < FULL) ? tx_shift[WIDTH-1] : 1'b0;
        end
        if (sclk_fall && (bit_cnt < FULL)) begin
          rx_shift_n = {rx_shift[WIDTH-2:0], mosi_s};
          tx_shift_n = {tx_shift[WIDTH-2:0], 1'b0};
          bit_cnt_n  = bit_cnt + CNT_W'(1);
        end
        // End-of-frame looks at the post-edge values so a same-cycle sclk edge counts.
        if (cs_rise) begin
          if (bit_cnt_n == FULL) begin
            rx_data_n  = rx_shift_n;
            rx_valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
          miso_n  = 1'b0;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign busy    = (state == ACTIVE);
  assign miso_oe = (state == ACTIVE);

endmodule

// File: tb/tb_spi_sub.sv
// Self-checking bench for spi_sub: table of directed frames plus random frames,
// checked against a word-level model of what each frame should deliver.
module tb_spi_sub;

  localparam int WIDTH = 128;

  logic             clk;
  logic             rst_n;
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic             miso_oe;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             frame_err;
  logic             busy;

  spi_sub #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               nbits;
    int               gap;
    int               change_at;
    int               rst_at;
    logic [WIDTH-1:0] tx;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] tx_new;
    int               exp_valid;
    int               exp_err;
  } vec_t;

  int               checks = 0;
  int               errors = 0;
  int               valid_cnt = 0;
  int               err_cnt = 0;
  logic [WIDTH-1:0] last_rx = '0;
  logic [WIDTH-1:0] model_rx = '0;

  // Pulse counters; a pulse longer than one clk shows up as an extra count.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_rx = rx_data;
    end
    if (frame_err) err_cnt++;
  end

  task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " miso"}, WIDTH'(miso), '0);
    check({tag, " miso_oe"}, WIDTH'(miso_oe), '0);
    check({tag, " rx_data"}, rx_data, '0);
    check({tag, " rx_valid"}, WIDTH'(rx_valid), '0);
    check({tag, " frame_err"}, WIDTH'(frame_err), '0);
    check({tag, " busy"}, WIDTH'(busy), '0);
  endtask

  // Plays one frame as the main would (clk = 8x sclk) and checks its outcome.
  task automatic run_frame(input vec_t v, input string tag);
    int   v0, e0, miso_bad;
    bit   did_rst;
    logic exp_bit;
    v0       = valid_cnt;
    e0       = err_cnt;
    miso_bad = 0;
    did_rst  = 1'b0;
    tx_data  = v.tx;
    cs_n     = 1'b0;
    repeat (8) @(negedge clk);
    check({tag, " busy in frame"}, WIDTH'(busy), WIDTH'(1));
    check({tag, " miso_oe in frame"}, WIDTH'(miso_oe), WIDTH'(1));
    for (int i = 0; i < v.nbits; i++) begin
      mosi = (i < WIDTH) ? v.word[WIDTH-1-i] : 1'($urandom);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      exp_bit = (i < WIDTH) ? v.tx[WIDTH-1-i] : 1'b0;
      if (!did_rst && (miso !== exp_bit)) miso_bad++;
      if (i == v.rst_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero({tag, " mid-frame reset"});
        @(negedge clk);
        rst_n   = 1'b1;
        did_rst = 1'b1;
      end
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      if (i == v.change_at) tx_data = v.tx_new;
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (v.gap) @(negedge clk);

    // Word-level model: a reset clears rx_data, a frame of at least WIDTH bits
    // delivers its first WIDTH bits, anything shorter leaves rx_data alone.
    if (did_rst) model_rx = '0;
    else if (v.nbits >= WIDTH) model_rx = v.word;

    check({tag, " rx_valid pulses"}, WIDTH'(valid_cnt - v0), WIDTH'(v.exp_valid));
    check({tag, " frame_err pulses"}, WIDTH'(err_cnt - e0), WIDTH'(v.exp_err));
    check({tag, " rx_data"}, rx_data, model_rx);
    check({tag, " miso bit errors"}, WIDTH'(miso_bad), '0);
    if (v.exp_valid != 0) check({tag, " rx_data at rx_valid"}, last_rx, model_rx);
    check({tag, " busy after"}, WIDTH'(busy), '0);
    check({tag, " miso_oe after"}, WIDTH'(miso_oe), '0);
    check({tag, " miso after"}, WIDTH'(miso), '0);
  endtask

  vec_t tbl[9];

  initial begin
    rst_n   = 1'b0;
    sclk    = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    tx_data = '0;

    //            nbits gap chg  rst  tx  word  tx_new  valid err
    tbl[0] = '{128, 10, -1, -1, 128'h00112233_44556677_8899AABB_CCDDEEFF,
               128'h0F0E0D0C_0B0A0908_07060504_03020100, '0, 1, 0};
    tbl[1] = '{100, 10, -1, -1, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
               128'h12345678_9ABCDEF0_0FEDCBA9_87654321, '0, 0, 1};
    tbl[2] = '{130, 10, -1, -1, 128'h80000000_00000000_00000000_00000001,
               128'hA1B2C3D4_E5F60718_293A4B5C_6D7E8F90, '0, 1, 0};
    tbl[3] = '{128, 10, 10, -1, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5,
               128'h13579BDF_02468ACE_FDB97531_ECA86420,
               128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A, 1, 0};
    tbl[4] = '{128, 10, -1, -1, 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A,
               128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF, '0, 1, 0};
    tbl[5] = '{128, 10, -1, 60, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000,
               128'h11111111_22222222_33333333_44444444, '0, 0, 0};
    tbl[6] = '{128, 10, -1, -1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'h55555555_AAAAAAAA_55555555_AAAAAAAA, '0, 1, 0};
    tbl[7] = '{128, 4, -1, -1, 128'h76543210_FEDCBA98_01234567_89ABCDEF,
               {WIDTH{1'b1}}, '0, 1, 0};
    tbl[8] = '{128, 10, -1, -1, 128'h3C3C3C3C_C3C3C3C3_3C3C3C3C_C3C3C3C3,
               '0, '0, 1, 0};

    repeat (3) @(negedge clk);
    check_all_zero("in reset");
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_all_zero("after reset");

    for (int k = 0; k < 9; k++) run_frame(tbl[k], $sformatf("vec%0d", k));

    for (int k = 0; k < 6; k++) begin
      vec_t r;
      r.nbits     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(110, 140)) : WIDTH;
      r.gap       = int'($urandom_range(4, 12));
      r.change_at = int'($urandom_range(0, 100));
      r.rst_at    = -1;
      r.tx        = {$urandom, $urandom, $urandom, $urandom};
      r.word      = {$urandom, $urandom, $urandom, $urandom};
      r.tx_new    = {$urandom, $urandom, $urandom, $urandom};
      r.exp_valid = (r.nbits >= WIDTH) ? 1 : 0;
      r.exp_err   = (r.nbits < WIDTH) ? 1 : 0;
      run_frame(r, $sformatf("rand%0d n=%0d", k, r.nbits));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
